rosc_gate_mon: RTL and testbench
================================

ROSC_GATE_MON -- requirements
Module: rosc_gate_mon

Interface
REQ-001 Parameter NUM_CH, default 4, number of ring-oscillator channels.
REQ-002 Parameter CNT_W, default 16, edge-counter width per channel.
REQ-003 Parameter WIN_W, default 16, measurement-window length width.
REQ-004 Parameter SETTLE_CYC, default 8, axi_clk cycles between gate enable and count start; SHALL be >= 1.
REQ-005 axi_clk  in  1  single clock for all sequential logic.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 rosc_node  in  NUM_CH  raw oscillator nodes, asynchronous to axi_clk.
REQ-008 ch_en_mask  in  NUM_CH  channels to enable and measure, sampled on start.
REQ-009 win_len  in  WIN_W  measurement window in axi_clk cycles, sampled on start.
REQ-010 start  in  1  single-cycle request to run one measurement.
REQ-011 abort  in  1  cancel the run in progress.
REQ-012 busy  out  1  high from SETTLE through DONE.
REQ-013 done  out  1  one-cycle pulse at run completion.
REQ-014 cnt_valid  out  1  cnt_data holds the results of the last completed run.
REQ-015 cnt_data  out  NUM_CH*CNT_W  per-channel edge counts, channel i at bits [i*CNT_W +: CNT_W].
REQ-016 ovf  out  NUM_CH  per-channel counter saturation flag.
REQ-017 freq_out  out  NUM_CH  gated oscillator outputs, freq_out[i] = rosc_node[i] AND gate_en[i].

Function
REQ-018 FSM states SHALL be IDLE, SETTLE, MEASURE, DONE.
REQ-019 IDLE -> SETTLE when start=1, abort=0 and ch_en_mask != 0; mask and win_len SHALL be latched on that edge.
REQ-020 start with ch_en_mask == 0 SHALL be ignored.
REQ-021 start outside IDLE SHALL be ignored; latched mask and window SHALL be unchanged.
REQ-022 On SETTLE entry: gate_en SHALL equal the latched mask, all counters and ovf SHALL clear, cnt_valid SHALL drop.
REQ-023 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to MEASURE; with latched win_len == 0 it goes directly to DONE.
REQ-024 MEASURE SHALL last exactly win_len cycles, then go to DONE.
REQ-025 Each rosc_node bit SHALL pass a 2-flop synchronizer plus one history flop; a rising edge is sync=1, history=0.
REQ-026 A counter SHALL increment by 1 per detected rising edge only in MEASURE and only for latched-enabled channels.
REQ-027 DONE SHALL last one cycle: done=1, cnt_valid=1, gate_en cleared; next state IDLE.
REQ-028 Latency: start sampled at cycle t -> busy at t+1 -> done at cycle t+1+SETTLE_CYC+win_len.
REQ-029 cnt_data and ovf SHALL hold their values after DONE until the next accepted start.
REQ-030 abort=1 in any state SHALL return to IDLE on the next edge, clear gate_en and cnt_valid, and SHALL NOT produce done.
REQ-031 start and abort asserted together SHALL be treated as abort.

Reset
REQ-032 reset SHALL force IDLE, gate_en=0, busy=0, done=0, cnt_valid=0, cnt_data=0, ovf=0 and synchronizer flops=0; freq_out SHALL therefore be 0.
REQ-033 reset asserted mid-run SHALL take effect immediately with no done pulse.

Configuration
REQ-034 Macro ROSC_MON_SAT_EN defined: a counter at 2^CNT_W-1 SHALL hold that value and set its ovf bit until the next run.
REQ-035 Macro ROSC_MON_SAT_EN undefined: counters SHALL wrap modulo 2^CNT_W and ovf SHALL be tied to 0.

Structure
REQ-036 Package rosc_mon_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-037 Sub-module rosc_mon_ch SHALL contain one channel's synchronizer, edge detector, counter and saturation logic, instantiated NUM_CH times.

Verification
REQ-038 Reset release, then start with mask=4'b0101, win_len=100 and rosc_node[0] toggling every 4 cycles -> done at start+109, cnt ch0 = 12 or 13 (+-1), ch1..3 = 0.
REQ-039 start with mask=0 -> busy stays 0, no done, cnt_valid unchanged.
REQ-040 abort at cycle 50 of MEASURE -> IDLE next cycle, freq_out = 0, no done, cnt_valid = 0.
REQ-041 CNT_W=4, win_len=200, ch0 toggling every 2 cycles -> with macro cnt=15 and ovf[0]=1; without macro cnt = edges mod 16 and ovf=0.
REQ-042 Second start during MEASURE -> ignored; done at the original cycle; new start afterwards runs normally.
REQ-043 win_len=0, mask=4'b1111 -> done at start+1+SETTLE_CYC, all counts 0, cnt_valid=1.

Source files
------------

// File: rtl/rosc_mon_pkg.sv
// rosc_mon_pkg: FSM state type and default parameters shared by rosc_gate_mon and rosc_mon_ch
package rosc_mon_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_WIN_W = 16;
  localparam int DEF_SETTLE_CYC = 8;
  function automatic int max_i(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/rosc_mon_ch.sv
// rosc_mon_ch: one oscillator channel - synchronizer, rising-edge detect, edge counter.
// ROSC_MON_SAT_EN defined: counter saturates and flags ovf; undefined: counter wraps, ovf tied low.
module rosc_mon_ch #(
  parameter int CNT_W = 16
) (
  input  logic             axi_clk,
  input  logic             reset,
  input  logic             rosc_node,
  input  logic             clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  // sh[0] metastability flop, sh[1] synchronized value, sh[2] history
  logic [2:0] sh;
  logic       rise;
  assign rise = sh[1] & ~sh[2];
  always_ff @(posedge axi_clk or posedge reset)
    if (reset) sh <= '0;
    else sh <= {sh[1:0], rosc_node};
`ifdef ROSC_MON_SAT_EN
  always_ff @(posedge axi_clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (cnt_en && rise) begin
      if (&cnt) ovf <= 1'b1;
      else cnt <= cnt + CNT_W'(1);
    end
`else
  assign ovf = 1'b0;
  always_ff @(posedge axi_clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (cnt_en && rise) cnt <= cnt + CNT_W'(1);
`endif
endmodule

// File: rtl/rosc_gate_mon.sv
// rosc_gate_mon: gates ring oscillators and counts their edges over a programmable window.
// Optional macro ROSC_MON_SAT_EN selects saturating counters with overflow flags.
module rosc_gate_mon
  import rosc_mon_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WIN_W      = DEF_WIN_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                    axi_clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       rosc_node,
  input  logic [NUM_CH-1:0]       ch_en_mask,
  input  logic [WIN_W-1:0]        win_len,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    cnt_valid,
  output logic [NUM_CH*CNT_W-1:0] cnt_data,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH-1:0]       freq_out
);
  localparam int TMR_W = max_i(WIN_W, $clog2(SETTLE_CYC + 1));
  state_t             state, state_nxt;
  logic [TMR_W-1:0]   tmr, tmr_nxt;
  logic [NUM_CH-1:0]  mask_q, gate_en;
  logic [WIN_W-1:0]   win_q;
  logic               accept;
  assign accept   = state == IDLE && start && !abort && |ch_en_mask;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign freq_out = rosc_node & gate_en;
  // tmr counts down the remaining cycles of the current SETTLE or MEASURE phase
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    if (abort) state_nxt = IDLE;
    else
      case (state)
        IDLE: if (accept) begin
          state_nxt = SETTLE;
          tmr_nxt   = TMR_W'(SETTLE_CYC - 1);
        end
        SETTLE: if (tmr == '0) begin
          state_nxt = win_q == '0 ? DONE : MEASURE;
          tmr_nxt   = TMR_W'(win_q) - TMR_W'(1);
        end else tmr_nxt = tmr - TMR_W'(1);
        MEASURE: if (tmr == '0) state_nxt = DONE;
        else tmr_nxt = tmr - TMR_W'(1);
        default: state_nxt = IDLE;
      endcase
  end
  always_ff @(posedge axi_clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      tmr       <= '0;
      mask_q    <= '0;
      win_q     <= '0;
      gate_en   <= '0;
      cnt_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      if (accept) begin
        mask_q <= ch_en_mask;
        win_q  <= win_len;
      end
      gate_en   <= abort ? '0 : accept ? ch_en_mask : state_nxt == DONE ? '0 : gate_en;
      cnt_valid <= abort || accept ? 1'b0 : state_nxt == DONE ? 1'b1 : cnt_valid;
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rosc_mon_ch #(.CNT_W(CNT_W)) u_ch (
      .axi_clk  (axi_clk),
      .reset    (reset),
      .rosc_node(rosc_node[i]),
      .clr      (accept),
      .cnt_en   (state == MEASURE && mask_q[i]),
      .cnt      (cnt_data[i*CNT_W +: CNT_W]),
      .ovf      (ovf[i])
    );
  end
endmodule

// File: tb/tb_rosc_gate_mon.sv
// tb_rosc_gate_mon: scoreboard bench for rosc_gate_mon with a window-based edge-count model.
module tb_rosc_gate_mon;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
  localparam int WIN_W  = 16;
  localparam int S      = 8;
  localparam int CW     = NUM_CH * CNT_W;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic              axi_clk = 1'b0, reset = 1'b1;
  logic [NUM_CH-1:0] rosc_node = '0, ch_en_mask = '0;
  logic [WIN_W-1:0]  win_len = '0;
  logic              start = 1'b0, abort = 1'b0;
  logic              busy, done, cnt_valid;
  logic [CW-1:0]     cnt_data;
  logic [NUM_CH-1:0] ovf, freq_out;

  rosc_gate_mon #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(S)) dut (
    .axi_clk(axi_clk), .reset(reset), .rosc_node(rosc_node), .ch_en_mask(ch_en_mask),
    .win_len(win_len), .start(start), .abort(abort), .busy(busy), .done(done),
    .cnt_valid(cnt_valid), .cnt_data(cnt_data), .ovf(ovf), .freq_out(freq_out)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct {
    int                cyc;
    logic [CW-1:0]     cnt;
    logic [NUM_CH-1:0] ovf;
  } exp_t;

  exp_t              sbq[$];
  int                n_chk = 0, n_pass = 0, n_done = 0, cyc = 0;
  logic [NUM_CH-1:0] w [0:511];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
  endtask

  // Node value w[j] is present at the j-th clock edge after start is taken (j=0).
  // A 0->1 step between w[j-1] and w[j] is seen by the channel two edges later,
  // so it lands inside the window when S-1 <= j <= S+wl-2.
  function automatic exp_t model(input logic [NUM_CH-1:0] m, input int wl, input int t0);
    exp_t e;
    e.cyc = t0 + S + wl;
    e.cnt = '0;
    e.ovf = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int edges = 0;
      if (m[i])
        for (int j = S - 1; j <= S + wl - 2; j++)
          if (w[j][i] && !(j > 0 ? w[j-1][i] : 1'b0)) edges++;
`ifdef ROSC_MON_SAT_EN
      e.cnt[i*CNT_W +: CNT_W] = CNT_W'(edges > MAXC ? MAXC : edges);
      e.ovf[i] = edges > MAXC;
`else
      e.cnt[i*CNT_W +: CNT_W] = CNT_W'(edges % (MAXC + 1));
`endif
    end
    return e;
  endfunction

  always @(posedge axi_clk) cyc <= cyc + 1;

  always @(posedge axi_clk) begin
    #1;
    if (done) begin
      n_done++;
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("cnt_data", cnt_data, e.cnt);
        chk("ovf", ovf, e.ovf);
        chk("valid_at_done", cnt_valid, 1);
        chk("busy_at_done", busy, 1);
      end
    end
  end

  // ab: edge index of abort (-1 none); rs: edge index of an ignored second start (-1 none)
  task automatic run(input logic [NUM_CH-1:0] m, input int wl, input int h0, input int ab, input int rs);
    int   hh[NUM_CH];
    int   ph[NUM_CH];
    int   t0, n0;
    exp_t e;
    for (int i = 0; i < NUM_CH; i++) begin
      hh[i] = h0 > 0 ? (i == 0 ? h0 : 0) : int'($urandom_range(0, 6));
      ph[i] = h0 > 0 ? 0 : int'($urandom_range(0, 7));
    end
    for (int j = 0; j < S + wl + 6; j++)
      for (int i = 0; i < NUM_CH; i++)
        w[j][i] = j > S + wl + 1 ? 1'b0 : hh[i] == 0 ? 1'b0 :
                  hh[i] == 6 ? 1'($urandom_range(0, 1)) : 1'(((j + ph[i]) / hh[i]) % 2);
    n0 = n_done;
    t0 = 0;
    for (int j = 0; j < S + wl + 6; j++) begin
      @(negedge axi_clk);
      rosc_node = w[j];
      abort = (j == ab);
      if (j == 0) begin
        start = 1'b1;
        ch_en_mask = m;
        win_len = WIN_W'(wl);
      end else start = (j == rs);
      if (j == rs) begin
        ch_en_mask = NUM_CH'($urandom_range(1, 15));
        win_len = WIN_W'($urandom_range(0, 50));
      end
      if (j == 1) begin
        t0 = cyc;
        if (ab < 0) begin
          e = model(m, wl, t0);
          sbq.push_back(e);
        end
      end
      if (j == S && (ab < 0 || ab >= S)) begin
        #1 chk("freq_out_gated", freq_out, w[S] & m);
      end
      if (ab > 0 && j == ab + 1) begin
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_freq_out", freq_out, 0);
        chk("abort_valid", cnt_valid, 0);
      end
    end
    rosc_node = '0;
    start = 1'b0;
    abort = 1'b0;
    chk("no_pending_done", sbq.size(), 0);
    chk("done_count", n_done - n0, ab < 0 ? 1 : 0);
    if (ab < 0) begin
      chk("hold_cnt", cnt_data, e.cnt);
      chk("hold_ovf", ovf, e.ovf);
      chk("hold_valid", cnt_valid, 1);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    int   n0, ab, rs, wl;
    logic v;
    rosc_node = '1;
    repeat (3) @(negedge axi_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", cnt_valid, 0);
    chk("rst_cnt", cnt_data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_freq_out", freq_out, 0);
    reset = 1'b0;
    rosc_node = '0;
    repeat (4) @(negedge axi_clk);

    run(4'b0101, 100, 4, -1, -1);
    // zero mask must be ignored
    n0 = n_done;
    v = cnt_valid;
    @(negedge axi_clk);
    start = 1'b1;
    ch_en_mask = '0;
    win_len = 10;
    @(negedge axi_clk);
    start = 1'b0;
    #1 chk("mask0_busy_now", busy, 0);
    repeat (20) @(negedge axi_clk);
    chk("mask0_busy", busy, 0);
    chk("mask0_no_done", n_done - n0, 0);
    chk("mask0_valid", cnt_valid, v);

    run(4'b0001, 200, 2, -1, -1);
    run(4'b1111, 0, 0, -1, -1);
    run(4'b1111, 100, 0, S + 50, -1);
    run(4'b0011, 60, 0, -1, S + 20);
    run(4'b1010, 30, 3, -1, -1);

    // start together with abort behaves as abort
    n0 = n_done;
    @(negedge axi_clk);
    start = 1'b1;
    abort = 1'b1;
    ch_en_mask = '1;
    win_len = 5;
    @(negedge axi_clk);
    start = 1'b0;
    abort = 1'b0;
    #1 chk("start_abort_busy", busy, 0);
    repeat (20) @(negedge axi_clk);
    chk("start_abort_no_done", n_done - n0, 0);

    for (int k = 0; k < 25; k++) begin
      wl = $urandom_range(0, 120);
      ab = ($urandom % 7 == 0) ? int'($urandom_range(1, S + wl)) : -1;
      rs = (ab < 0 && $urandom % 3 == 0) ? int'($urandom_range(2, S + wl)) : -1;
      run(NUM_CH'($urandom_range(1, 15)), wl, 0, ab, rs);
    end

    // asynchronous reset in the middle of a run
    n0 = n_done;
    @(negedge axi_clk);
    start = 1'b1;
    ch_en_mask = '1;
    win_len = 60;
    @(negedge axi_clk);
    start = 1'b0;
    repeat (20) begin
      @(negedge axi_clk);
      rosc_node = ~rosc_node;
    end
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt", cnt_data, 0);
    chk("midrst_valid", cnt_valid, 0);
    chk("midrst_freq_out", freq_out, 0);
    @(negedge axi_clk);
    reset = 1'b0;
    rosc_node = '0;
    repeat (80) @(negedge axi_clk);
    chk("midrst_no_done", n_done - n0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
